// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receive deserializer with runtime baud divisor and mid-bit sampling
module uart_rx (
    input  logic        clk,
    input  logic        rst,
    input  logic        rxd,
    input  logic [15:0] bauddiv,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic        frame_err,
    output logic        break_det,
    output logic        busy
);
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAITHI} state_t;
    state_t      state, state_n;
    logic        s1, rxd_s;
    logic [15:0] d, cnt;
    logic [2:0]  bitcnt;
    logic [7:0]  shreg;
    logic        cnt_zero;
    assign cnt_zero = cnt == 16'd0;
    assign busy     = state != IDLE;
    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end
    // next-state decode; WAITHI keeps a held-low line from retriggering frames
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = rxd_s ? IDLE : START;
            START:   state_n = cnt_zero ? (rxd_s ? IDLE : DATA) : START;
            DATA:    state_n = (cnt_zero && bitcnt == 3'd7) ? STOP : DATA;
            STOP:    state_n = cnt_zero ? (rxd_s ? IDLE : WAITHI) : STOP;
            WAITHI:  state_n = rxd_s ? IDLE : WAITHI;
            default: state_n = IDLE;
        endcase
    end
    // synchronizer, bit timing counters, shift register and result strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            s1        <= 1'b1;
            rxd_s     <= 1'b1;
            d         <= '0;
            cnt       <= '0;
            bitcnt    <= '0;
            shreg     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            break_det <= 1'b0;
        end else begin
            s1        <= rxd;
            rxd_s     <= s1;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            break_det <= 1'b0;
            case (state)
                IDLE: if (!rxd_s) begin
                    d   <= bauddiv;
                    cnt <= bauddiv >> 1;
                end
                START: begin
                    cnt    <= cnt_zero ? d : cnt - 16'd1;
                    bitcnt <= 3'd0;
                end
                DATA: if (cnt_zero) begin
                    shreg  <= {rxd_s, shreg[7:1]};
                    cnt    <= d;
                    bitcnt <= bitcnt + 3'd1;
                end else begin
                    cnt <= cnt - 16'd1;
                end
                STOP: if (cnt_zero) begin
                    if (rxd_s) begin
                        rx_data  <= shreg;
                        rx_valid <= 1'b1;
                    end else begin
                        frame_err <= |shreg;
                        break_det <= ~|shreg;
                    end
                end else begin
                    cnt <= cnt - 16'd1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: table-driven and directed checks of the uart_rx deserializer
module tb_uart_rx;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rxd = 1'b1;
    logic [15:0] bauddiv = 16'd9;
    logic [7:0]  rx_data;
    logic        rx_valid, frame_err, break_det, busy;

    uart_rx dut (
        .clk(clk), .rst(rst), .rxd(rxd), .bauddiv(bauddiv),
        .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err),
        .break_det(break_det), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int nv = 0, nf = 0, nb = 0, multi = 0, busy_on_valid = 0;
    int vtime[$];
    logic [7:0] vdata[$];
    // record every strobe as seen between clock edges
    always @(negedge clk) begin
        if (rx_valid) begin
            nv++;
            vtime.push_back(cyc);
            vdata.push_back(rx_data);
            if (busy) busy_on_valid++;
        end
        if (frame_err) nf++;
        if (break_det) nb++;
        if (int'(rx_valid) + int'(frame_err) + int'(break_det) > 1) multi++;
    end

    int checks = 0, failures = 0;
    int c0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // drive one frame with bit period p clocks; caller must be at a negedge
    task automatic send(input int p, input logic [7:0] b, input logic stop, input int hold,
                        input logic chg, input logic [15:0] newdiv);
        rxd = 1'b0;
        c0 = cyc;
        repeat (p) @(negedge clk);
        if (chg) bauddiv = newdiv;
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (p) @(negedge clk);
        end
        rxd = stop;
        repeat (p * (1 + hold)) @(negedge clk);
        rxd = 1'b1;
    endtask

    function automatic int exp_time(input int start, input int dv);
        return start + 4 + (dv >> 1) + 9 * (dv + 1);
    endfunction

    typedef struct {
        logic [15:0] div;
        logic [7:0]  data;
        logic        stop;
        int          hold;
        int          ev;
        int          ef;
        int          eb;
        logic [7:0]  erx;
    } vec_t;

    vec_t tab[7];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int v0, f0, b0, t1, first_c0;
        tab[0] = '{16'd9, 8'hA5, 1'b1, 0,  1, 0, 0, 8'hA5};
        tab[1] = '{16'd9, 8'h3C, 1'b0, 1,  0, 1, 0, 8'hA5};
        tab[2] = '{16'd9, 8'h5A, 1'b1, 0,  1, 0, 0, 8'h5A};
        tab[3] = '{16'd9, 8'h00, 1'b0, 20, 0, 0, 1, 8'h5A};
        tab[4] = '{16'd9, 8'h81, 1'b1, 0,  1, 0, 0, 8'h81};
        tab[5] = '{16'd2, 8'h69, 1'b1, 0,  1, 0, 0, 8'h69};
        tab[6] = '{16'd3, 8'hF0, 1'b1, 0,  1, 0, 0, 8'hF0};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset rx_data", int'(rx_data), 0);
        chk("reset rx_valid", int'(rx_valid), 0);
        chk("reset frame_err", int'(frame_err), 0);
        chk("reset break_det", int'(break_det), 0);
        chk("reset busy", int'(busy), 0);
        repeat (4) @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            v0 = nv; f0 = nf; b0 = nb;
            bauddiv = tab[i].div;
            send(int'(tab[i].div) + 1, tab[i].data, tab[i].stop, tab[i].hold, 1'b0, 16'd0);
            repeat (3 * (int'(tab[i].div) + 1)) @(negedge clk);
            chk($sformatf("vec%0d valid count", i), nv - v0, tab[i].ev);
            chk($sformatf("vec%0d frame_err count", i), nf - f0, tab[i].ef);
            chk($sformatf("vec%0d break count", i), nb - b0, tab[i].eb);
            chk($sformatf("vec%0d rx_data", i), int'(rx_data), int'(tab[i].erx));
            chk($sformatf("vec%0d busy idle", i), int'(busy), 0);
            if (tab[i].ev == 1 && nv > v0) begin
                chk($sformatf("vec%0d valid time", i), vtime[$], exp_time(c0, int'(tab[i].div)));
                chk($sformatf("vec%0d strobe data", i), int'(vdata[$]), int'(tab[i].data));
            end
        end

        // back-to-back frames with no idle gap
        v0 = nv; f0 = nf; b0 = nb;
        bauddiv = 16'd9;
        send(10, 8'h00, 1'b1, 0, 1'b0, 16'd0);
        first_c0 = c0;
        send(10, 8'hFF, 1'b1, 0, 1'b0, 16'd0);
        repeat (30) @(negedge clk);
        chk("b2b valid count", nv - v0, 2);
        chk("b2b error count", (nf - f0) + (nb - b0), 0);
        if (nv - v0 == 2) begin
            t1 = vtime[$ - 1];
            chk("b2b first time", t1, exp_time(first_c0, 9));
            chk("b2b spacing", vtime[$] - t1, 100);
            chk("b2b first data", int'(vdata[$ - 1]), 8'h00);
            chk("b2b second data", int'(vdata[$]), 8'hFF);
        end

        // start-bit glitch is rejected, next frame still received
        v0 = nv; f0 = nf; b0 = nb;
        bauddiv = 16'd15;
        rxd = 1'b0;
        repeat (3) @(negedge clk);
        rxd = 1'b1;
        repeat (2) @(negedge clk);
        chk("glitch busy high", int'(busy), 1);
        repeat (20) @(negedge clk);
        chk("glitch busy low", int'(busy), 0);
        chk("glitch no strobes", (nv - v0) + (nf - f0) + (nb - b0), 0);
        send(16, 8'h3C, 1'b1, 0, 1'b0, 16'd0);
        repeat (40) @(negedge clk);
        chk("post-glitch valid count", nv - v0, 1);
        chk("post-glitch rx_data", int'(rx_data), 8'h3C);

        // reset during data bit 4 aborts the frame
        v0 = nv; f0 = nf; b0 = nb;
        bauddiv = 16'd9;
        rxd = 1'b0;
        repeat (10) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rxd = (8'hC3 >> i) & 8'h01;
            repeat (10) @(negedge clk);
        end
        rxd = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        rxd = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort rx_data", int'(rx_data), 0);
        chk("abort rx_valid", int'(rx_valid), 0);
        chk("abort busy", int'(busy), 0);
        repeat (200) @(negedge clk);
        chk("abort no strobes", (nv - v0) + (nf - f0) + (nb - b0), 0);

        // bauddiv changed mid-frame: frame decodes at the latched divisor
        send(10, 8'hC3, 1'b1, 0, 1'b1, 16'd4);
        repeat (30) @(negedge clk);
        chk("latched-D valid count", nv - v0, 1);
        chk("latched-D rx_data", int'(rx_data), 8'hC3);
        if (nv - v0 == 1) chk("latched-D valid time", vtime[$], exp_time(c0, 9));

        chk("busy clear on valid", busy_on_valid, 0);
        chk("strobes mutually exclusive", multi, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
